// File: rtl/window_frame_sequencer.sv
// Frame sequencer for the 3x3 line-buffer window generator: feeds pixels, flushes the
// last row with pad pushes, tags each produced window with centre row/col and border.
module window_frame_sequencer #(
  parameter int                    WIDTH      = 640,
  parameter int                    DEPTH      = 506,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  lb_start,
  output logic                  lb_data_en,
  output logic [DATA_WIDTH-1:0] lb_data,
  output logic                  win_valid,
  output logic [9:0]            win_row,
  output logic [9:0]            win_col,
  output logic                  border,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  err_overrun
);

  localparam int PW = $clog2(WIDTH * DEPTH + WIDTH + 2);
  localparam int FW = $clog2(WIDTH + 3);

  localparam logic [9:0]    LAST_COL  = 10'(WIDTH - 1);
  localparam logic [9:0]    LAST_ROW  = 10'(DEPTH - 1);
  localparam logic [PW-1:0] FIRST_WIN = PW'(WIDTH + 1);
  localparam logic [FW-1:0] LAST_PAD  = FW'(WIDTH);
  localparam logic [FW-1:0] DRAIN_END = FW'(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t        state;
  logic [9:0]    in_row;
  logic [9:0]    in_col;
  logic [9:0]    c_row;
  logic [9:0]    c_col;
  logic [PW-1:0] push_cnt;
  logic [FW-1:0] flush_cnt;
  logic          win_pend;
  logic          handshake;

  assign handshake = s_valid & s_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      s_ready     <= 1'b0;
      lb_start    <= 1'b0;
      lb_data_en  <= 1'b0;
      lb_data     <= '0;
      win_valid   <= 1'b0;
      win_row     <= '0;
      win_col     <= '0;
      border      <= 1'b0;
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
      in_row      <= '0;
      in_col      <= '0;
      c_row       <= '0;
      c_col       <= '0;
      push_cnt    <= '0;
      flush_cnt   <= '0;
      win_pend    <= 1'b0;
    end else begin
      lb_data_en <= 1'b0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_pend   <= 1'b0;

      // A push that completes a window is tagged one cycle after it reaches the generator.
      if (win_pend) begin
        win_valid <= 1'b1;
        win_row   <= c_row;
        win_col   <= c_col;
        border    <= (c_row == '0) || (c_row == LAST_ROW) ||
                     (c_col == '0) || (c_col == LAST_COL);
        if (c_col == LAST_COL) begin
          c_col <= '0;
          c_row <= c_row + 10'd1;
        end else begin
          c_col <= c_col + 10'd1;
        end
      end

      if (abort) begin
        state      <= IDLE;
        s_ready    <= 1'b0;
        lb_start   <= 1'b0;
        lb_data_en <= 1'b0;
        win_valid  <= 1'b0;
        win_pend   <= 1'b0;
        frame_done <= 1'b0;
        in_row     <= '0;
        in_col     <= '0;
        c_row      <= '0;
        c_col      <= '0;
        push_cnt   <= '0;
        flush_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (frame_start) begin
              state    <= RUN;
              s_ready  <= 1'b1;
              lb_start <= 1'b1;
            end
          end
          RUN: begin
            if (frame_start) err_overrun <= 1'b1;
            if (handshake) begin
              lb_data    <= s_data;
              lb_data_en <= 1'b1;
              push_cnt   <= push_cnt + 1'b1;
              win_pend   <= (push_cnt >= FIRST_WIN);
              if (in_col == LAST_COL) begin
                in_col <= '0;
                if (in_row == LAST_ROW) begin
                  in_row  <= '0;
                  state   <= FLUSH;
                  s_ready <= 1'b0;
                end else begin
                  in_row <= in_row + 10'd1;
                end
              end else begin
                in_col <= in_col + 10'd1;
              end
            end
          end
          FLUSH: begin
            if (frame_start) err_overrun <= 1'b1;
            // WIDTH+1 pad pushes, then two drain cycles so the final window precedes frame_done.
            if (flush_cnt <= LAST_PAD) begin
              lb_data    <= PAD_VALUE;
              lb_data_en <= 1'b1;
              push_cnt   <= push_cnt + 1'b1;
              win_pend   <= (push_cnt >= FIRST_WIN);
            end
            if (flush_cnt == DRAIN_END) begin
              state      <= DONE;
              frame_done <= 1'b1;
              lb_start   <= 1'b0;
              flush_cnt  <= '0;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
          DONE: begin
            push_cnt <= '0;
            c_row    <= '0;
            c_col    <= '0;
            if (frame_start) begin
              state    <= RUN;
              s_ready  <= 1'b1;
              lb_start <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
